// File: rtl/counter_60_pkg.sv
// Shared constants for the modulo-60 BCD counter: digit limits and register widths.
package counter_60_pkg;

    localparam int ONES_MAX = 9;
    localparam int TENS_MAX = 5;
    localparam int ONES_W   = 4;
    localparam int TENS_W   = 3;

endpackage

// File: rtl/mod_n_digit.sv
// Single modulo-N digit register with enable, terminal-count decode and
// recovery of out-of-range values back to zero.
module mod_n_digit #(
    parameter int N = 10,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         tc
);

    localparam logic [W-1:0] QMAX = W'(N - 1);

    // Out-of-range values clear on the next edge whether or not en is high,
    // so an upset digit never waits for its upstream carry to recover.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else if (q > QMAX)
            q <= '0;
        else if (en)
            q <= (q == QMAX) ? '0 : q + W'(1);
    end

    // An illegal value can never equal QMAX, so tc stays low in that case.
    assign tc = (q == QMAX);

endmodule

// File: rtl/counter_60.sv
// Modulo-60 BCD counter (ones 0-9, tens 0-5) with a carry that is high
// during count 59, for cascading seconds/minutes stages.
module counter_60
    import counter_60_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic [ONES_W-1:0] CNT10,
    output logic [TENS_W-1:0] CNT6,
    output logic              CAR
);

    logic ones_tc;
    logic tens_tc;

    mod_n_digit #(.N(ONES_MAX + 1), .W(ONES_W)) u_ones (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .q   (CNT10),
        .tc  (ones_tc)
    );

    // Tens only advances on the edge that wraps the ones digit.
    mod_n_digit #(.N(TENS_MAX + 1), .W(TENS_W)) u_tens (
        .clk (clk),
        .rst (rst),
        .en  (ones_tc),
        .q   (CNT6),
        .tc  (tens_tc)
    );

    assign CAR = ones_tc & tens_tc;

endmodule

// File: tb/tb_counter_60.sv
// Scoreboard bench for counter_60: the stimulus process pushes the expected
// digits after each event, a separate monitor pops and compares them.
module tb_counter_60;

    logic       clk;
    logic       rst;
    logic [3:0] CNT10;
    logic [2:0] CNT6;
    logic       CAR;

    typedef struct {
        string      name;
        logic [2:0] cnt6;
        logic [3:0] cnt10;
        logic       car;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   model   = 0;
    int   car_hits;

    counter_60 dut (
        .clk   (clk),
        .rst   (rst),
        .CNT10 (CNT10),
        .CNT6  (CNT6),
        .CAR   (CAR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input string name, input int cnt);
        exp_t e;
        e.name  = name;
        e.cnt6  = 3'(cnt / 10);
        e.cnt10 = 4'(cnt % 10);
        e.car   = (cnt == 59);
        exp_q.push_back(e);
    endtask

    // One rising edge with rst high: advance the reference and expect it.
    task automatic step(input string name);
        @(posedge clk);
        #1;
        model = (model + 1) % 60;
        if (CAR) car_hits++;
        push_exp(name, model);
    endtask

    // Monitor: compare whatever the stimulus expects against the live outputs.
    initial begin
        exp_t e;
        forever begin
            wait (exp_q.size() != 0);
            e = exp_q.pop_front();
            n_total++;
            if (CNT6 === e.cnt6 && CNT10 === e.cnt10 && CAR === e.car)
                n_pass++;
            else
                $display("FAIL %s: got CNT6=%0d CNT10=%0d CAR=%b, want CNT6=%0d CNT10=%0d CAR=%b",
                         e.name, CNT6, CNT10, CAR, e.cnt6, e.cnt10, e.car);
        end
    end

    initial begin
        rst = 1'b0;
        #2;
        push_exp("reset_state", 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            push_exp("reset_hold", 0);
        end

        @(negedge clk);
        rst = 1'b1;
        model = 0;
        car_hits = 0;
        // 180 edges from reset cover 9->10, 59 with CAR, 59->00 three times.
        for (int i = 1; i <= 180; i++)
            step($sformatf("count_edge%0d", i));
        n_total++;
        if (car_hits == 3) n_pass++;
        else $display("FAIL car_hits: got %0d, want 3", car_hits);

        for (int i = 0; i < 37; i++) step("to_37");
        @(negedge clk);
        rst = 1'b0;
        #1;
        model = 0;
        push_exp("async_rst_at_37", 0);
        @(posedge clk);
        #1;
        push_exp("rst_hold_after_37", 0);
        @(negedge clk);
        rst = 1'b1;
        step("release_after_37");

        for (int i = 0; i < 58; i++) step("to_59");
        @(negedge clk);
        rst = 1'b0;
        #1;
        model = 0;
        push_exp("async_rst_at_59", 0);
        @(negedge clk);
        rst = 1'b1;
        step("release_after_59");
        step("after_59_second");

        #1;
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
